lifo_drain_ctrl: RTL and testbench

Downstream consumer of the LIFO memory. On a start command, it pops a requested number of words from the LIFO by driving POP and watching EMPTY. It absorbs the LIFO read latency and presents the words, newest first, as a valid/ready stream with a last marker on the final word. Typical uses are frame reversal and stack unwinding toward a downstream sink.

---
 rtl/lifo_pkg.sv | 25 ++
 rtl/lifo_skid_buf.sv | 72 +++++++
 rtl/lifo_drain_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_lifo_drain_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// -----------------------------------------------------------------------------
// lifo_pkg
// Shared definitions for the LIFO drain controller:
//   - state_t      : controller states (IDLE, DRAIN, FLUSH)
//   - DEF_*        : default word width and LIFO depth
//   - len_width()  : width needed to hold a length of 0..depth
// Optional build macro used by the controller: LIFO_DRAIN_STATS_EN.
// -----------------------------------------------------------------------------
package lifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_LIFO_DEPTH = 16;

   // One extra bit so that a length equal to the full depth is representable.
   function automatic int len_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/lifo_skid_buf.sv
// -----------------------------------------------------------------------------
// lifo_skid_buf
// Small circular FIFO that absorbs words arriving from the LIFO read pipe
// while the downstream sink is not ready.
// Ports:
//   clk_i, rst_i   : clock (rising edge), asynchronous active-high reset
//   push_i         : write push_data_i at the tail (caller guarantees room)
//   push_data_i    : word to write
//   pop_i          : drop the head word (caller guarantees occ_o != 0)
//   occ_o          : number of stored words
//   head_o         : oldest stored word
// -----------------------------------------------------------------------------
module lifo_skid_buf
   import lifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BUF_DEPTH  = 2,
   parameter int OCC_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [OCC_WIDTH-1:0]  occ_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   localparam int PTR_WIDTH = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(BUF_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_WIDTH-1:0]  occ_q, occ_d;

   // Depth need not be a power of two (READ_LATENCY = 2 gives 3 entries),
   // so the pointers wrap explicitly.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
      end
      if (pop_i) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
      end
      occ_d = occ_q + OCC_WIDTH'(push_i) - OCC_WIDTH'(pop_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
      end
   end

   assign occ_o  = occ_q;
   assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/lifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// lifo_drain_ctrl
// Pops a commanded number of words from an external LIFO and presents them,
// newest first, as a valid/ready stream with a last marker.
//
// Handshake: a word transfers on every rising edge where m_valid && m_ready;
// m_valid and m_data hold steady until that edge, and m_valid never depends
// on m_ready.
//
// Ports:
//   Clk, Rst    : clock (rising edge), asynchronous active-high reset
//   start, len  : command pulse and word count (sampled only in IDLE;
//                 len = 0 just pulses done, len > LIFO_DEPTH is clamped)
//   busy        : high in DRAIN and FLUSH
//   done        : one-cycle pulse after the last word transfers
//   POP, EMPTY  : LIFO pop request / LIFO empty flag
//   lifo_data   : LIFO read data, valid READ_LATENCY cycles after a POP
//   m_valid, m_ready, m_data, m_last : output stream
//   dbg_state_o : current controller state (state_t encoding)
//   stall_cnt   : only with LIFO_DRAIN_STATS_EN defined; DRAIN cycles in
//                 which a pop was wanted but the LIFO was empty (cleared on
//                 start, saturating)
// Build macro: LIFO_DRAIN_STATS_EN.
// -----------------------------------------------------------------------------
module lifo_drain_ctrl
   import lifo_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int LIFO_DEPTH   = DEF_LIFO_DEPTH,
   parameter int LEN_WIDTH    = len_width(LIFO_DEPTH),
   parameter int READ_LATENCY = 1   // legal values 1..2
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  POP,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] lifo_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [1:0]            dbg_state_o
`ifdef LIFO_DRAIN_STATS_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   // One slot per in-flight read plus one for the word on the output.
   localparam int BUF_DEPTH  = READ_LATENCY + 1;
   localparam int OCC_WIDTH  = $clog2(BUF_DEPTH + 1);
   localparam int FILL_WIDTH = OCC_WIDTH + 2;
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(LIFO_DEPTH);

   state_t                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    issued_q, issued_d;
   logic [LEN_WIDTH-1:0]    sent_q, sent_d;
   logic [READ_LATENCY-1:0] pipe_q, pipe_d;
   logic                    done_q, done_d;

   logic                    pop;
   logic                    handshake;
   logic                    final_hs;
   logic                    want_more;
   logic                    room;
   logic [FILL_WIDTH-1:0]   inflight;
   logic [FILL_WIDTH-1:0]   fill;
   logic [OCC_WIDTH-1:0]    buf_occ;
   logic [DATA_WIDTH-1:0]   buf_head;

   lifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH),
      .OCC_WIDTH  (OCC_WIDTH)
   ) u_skid (
      .clk_i       (Clk),
      .rst_i       (Rst),
      .push_i      (pipe_q[READ_LATENCY-1]),
      .push_data_i (lifo_data),
      .pop_i       (handshake),
      .occ_o       (buf_occ),
      .head_o      (buf_head)
   );

   assign handshake = m_valid && m_ready;
   assign final_hs  = handshake && m_last;
   assign want_more = (issued_q < len_q);

   // Every issued pop owns a buffer slot from the moment it is issued, so
   // the skid buffer can never overflow regardless of m_ready.  A word
   // leaving this cycle frees its slot immediately, which is what allows
   // one word per cycle with a buffer of only READ_LATENCY + 1 entries.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + FILL_WIDTH'(pipe_q[i]);
      end
      fill = FILL_WIDTH'(buf_occ) + inflight - FILL_WIDTH'(handshake);
      room = (fill < FILL_WIDTH'(BUF_DEPTH));
   end

   // Read pipe: bit 0 is a pop issued last cycle; the top bit marks the
   // cycle in which lifo_data carries that pop's word.
   assign pipe_d = READ_LATENCY'({pipe_q, pop});

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      issued_d = issued_q;
      sent_d   = sent_q;
      done_d   = 1'b0;
      pop      = 1'b0;

      if (handshake) begin
         sent_d = sent_q + LEN_WIDTH'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  len_d    = (len > MAX_LEN) ? MAX_LEN : len;
                  issued_d = '0;
                  sent_d   = '0;
                  state_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            pop = !EMPTY && want_more && room;
            if (pop) begin
               issued_d = issued_q + LEN_WIDTH'(1);
               if (issued_q + LEN_WIDTH'(1) == len_q) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (final_hs) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= IDLE;
         len_q    <= '0;
         issued_q <= '0;
         sent_q   <= '0;
         pipe_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         issued_q <= issued_d;
         sent_q   <= sent_d;
         pipe_q   <= pipe_d;
         done_q   <= done_d;
      end
   end

`ifdef LIFO_DRAIN_STATS_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start) begin
         stall_d = '0;
      end else if (state_q == DRAIN && EMPTY && want_more && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign POP         = pop;
   assign m_valid     = (buf_occ != '0);
   assign m_data      = buf_head;
   assign m_last      = m_valid && (sent_q == len_q - LEN_WIDTH'(1));
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lifo_drain_ctrl
// Directed bench for lifo_drain_ctrl with a behavioural LIFO (1-cycle read
// latency) feeding it.  Each scenario task drives its stimulus and compares
// the collected stream against a hand-built expected queue.
// Build macro honoured: LIFO_DRAIN_STATS_EN (adds the stall_cnt check).
// -----------------------------------------------------------------------------
module tb_lifo_drain_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int LW    = 5;
   localparam int RL    = 1;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          start;
   logic [LW-1:0] len;
   logic          busy, done, POP, EMPTY;
   logic [DW-1:0] lifo_data;
   logic          m_valid, m_ready, m_last;
   logic [DW-1:0] m_data;
   logic [1:0]    dbg_state;
`ifdef LIFO_DRAIN_STATS_EN
   logic [15:0]   stall_cnt;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   lifo_drain_ctrl #(
      .DATA_WIDTH   (DW),
      .LIFO_DEPTH   (DEPTH),
      .LEN_WIDTH    (LW),
      .READ_LATENCY (RL)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .start       (start),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .POP         (POP),
      .EMPTY       (EMPTY),
      .lifo_data   (lifo_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .dbg_state_o (dbg_state)
`ifdef LIFO_DRAIN_STATS_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   // ---------------- clock / watchdog ----------------
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural LIFO ----------------
   logic [DW-1:0] stack [DEPTH];
   logic [4:0]    sp = '0;
   int            pop_cnt = 0;
   int            bad_pop = 0;
   logic          clr;
   int            push_n;
   logic [DW-1:0] push_v0, push_v1;

   assign EMPTY = (sp == 5'd0);

   always @(posedge Clk) begin
      if (POP) pop_cnt <= pop_cnt + 1;
      if (POP && EMPTY) bad_pop <= bad_pop + 1;
      if (clr) begin
         sp <= '0;
      end else if (POP && !EMPTY) begin
         lifo_data <= stack[4'(sp - 5'd1)];
         sp <= sp - 5'd1;
      end else if (push_n == 1) begin
         stack[4'(sp)] <= push_v0;
         sp <= sp + 5'd1;
      end else if (push_n == 2) begin
         stack[4'(sp)] <= push_v0;
         stack[4'(sp + 5'd1)] <= push_v1;
         sp <= sp + 5'd2;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic lifo_clear();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
   endtask

   task automatic lifo_push(input logic [DW-1:0] v);
      push_n  = 1;
      push_v0 = v;
      cycle();
      push_n  = 0;
   endtask

   task automatic send_start(input logic [LW-1:0] l);
      start = 1'b1;
      len   = l;
      cycle();
      start = 1'b0;
   endtask

   // Stream collector: mode 0 = ready always high, 1 = ready toggling 1/0.
   logic [DW-1:0] got_q[$];
   logic          last_q[$];
   logic [DW-1:0] exp_q[$];
   int            first_at, last_at, done_at, stab_err;

   task automatic sink(input int max_cyc, input int mode, input int n_words,
                       input bit want_done, output bit reached);
      bit            prev_stall;
      logic [DW-1:0] prev_data;
      got_q.delete();
      last_q.delete();
      first_at   = -1;
      last_at    = -1;
      done_at    = -1;
      stab_err   = 0;
      reached    = 1'b0;
      prev_stall = 1'b0;
      prev_data  = '0;
      for (int i = 0; i < max_cyc; i++) begin
         m_ready = (mode == 0) ? 1'b1 : ~i[0];
         #1;
         if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stab_err++;
         if (m_valid === 1'b1 && first_at < 0) first_at = i;
         if (m_valid === 1'b1 && m_ready) begin
            got_q.push_back(m_data);
            last_q.push_back(m_last);
            if (m_last === 1'b1) last_at = i;
         end
         if (done === 1'b1 && done_at < 0) done_at = i;
         prev_stall = (m_valid === 1'b1) && !m_ready;
         prev_data  = m_data;
         if (got_q.size() >= n_words && (!want_done || done_at >= 0)) begin
            reached = 1'b1;
            break;
         end
         cycle();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %0b want 0", busy); end
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %0b want 0", done); end
      vec_cnt++; if (POP !== 1'b0) begin err_cnt++; $display("FAIL rst_pop: got %0b want 0", POP); end
      vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %0b want 0", m_valid); end
      vec_cnt++; if (m_last !== 1'b0) begin err_cnt++; $display("FAIL rst_last: got %0b want 0", m_last); end
      vec_cnt++; if (m_data !== 8'h00) begin err_cnt++; $display("FAIL rst_data: got %h want 00", m_data); end
      vec_cnt++; if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
      Rst = 1'b0;
      cycle();
      vec_cnt++; if (busy !== 1'b0 || m_valid !== 1'b0) begin err_cnt++; $display("FAIL post_rst_idle: busy %0b valid %0b want 0 0", busy, m_valid); end
   endtask

   task automatic test_full_drain();
      bit ok;
      int p0;
      lifo_clear();
      exp_q.delete();
      for (int k = 0; k < 16; k++) lifo_push(8'(k));
      for (int k = 15; k >= 0; k--) exp_q.push_back(8'(k));
      p0 = pop_cnt;
      send_start(5'd16);
      sink(80, 0, 16, 1'b1, ok);
      vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL full_timeout: got %0d words want 16", got_q.size()); end
      vec_cnt++; if (first_at !== RL + 1) begin err_cnt++; $display("FAIL full_latency: got %0d want %0d", first_at, RL + 1); end
      for (int k = 0; k < 16; k++) begin
         vec_cnt++;
         if (got_q.size() <= k || got_q[k] !== exp_q[k] || last_q[k] !== (k == 15)) begin
            err_cnt++;
            $display("FAIL full_word%0d: got %h/%0b want %h/%0b", k,
                     (got_q.size() > k) ? got_q[k] : 8'hxx, (last_q.size() > k) ? last_q[k] : 1'bx,
                     exp_q[k], (k == 15));
         end
      end
      vec_cnt++; if (done_at !== last_at + 1) begin err_cnt++; $display("FAIL full_done_timing: got %0d want %0d", done_at, last_at + 1); end
      vec_cnt++; if (pop_cnt - p0 !== 16) begin err_cnt++; $display("FAIL full_pops: got %0d want 16", pop_cnt - p0); end
      cycle();
      vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL full_idle: done %0b busy %0b want 0 0", done, busy); end
   endtask

   task automatic test_ready_toggle();
      bit ok;
      lifo_clear();
      for (int k = 0; k < 4; k++) lifo_push(8'hA0 + 8'(k));
      exp_q = '{8'hA3, 8'hA2};
      send_start(5'd2);
      sink(40, 1, 2, 1'b1, ok);
      vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL tog_timeout: got %0d words want 2", got_q.size()); end
      for (int k = 0; k < 2; k++) begin
         vec_cnt++;
         if (got_q.size() <= k || got_q[k] !== exp_q[k] || last_q[k] !== (k == 1)) begin
            err_cnt++;
            $display("FAIL tog_word%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
      vec_cnt++; if (stab_err !== 0) begin err_cnt++; $display("FAIL tog_stable: got %0d changes while stalled want 0", stab_err); end
      vec_cnt++; if (EMPTY !== 1'b0 || sp !== 5'd2) begin err_cnt++; $display("FAIL tog_left: empty %0b depth %0d want 0 2", EMPTY, sp); end
      cycle();
   endtask

   task automatic test_empty_stall();
      bit ok;
      int p0, b0;
      lifo_clear();
      lifo_push(8'h31);
      lifo_push(8'h32);
      lifo_push(8'h33);
      p0 = pop_cnt;
      b0 = bad_pop;
      exp_q = '{8'h33, 8'h32, 8'h31};
      send_start(5'd5);
      sink(40, 0, 3, 1'b0, ok);
      vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL stall_timeout1: got %0d words want 3", got_q.size()); end
      for (int k = 0; k < 3; k++) begin
         vec_cnt++;
         if (got_q.size() <= k || got_q[k] !== exp_q[k] || last_q[k] !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_word%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
      vec_cnt++; if (busy !== 1'b1 || dbg_state !== 2'd1) begin err_cnt++; $display("FAIL stall_state: busy %0b state %0d want 1 1", busy, dbg_state); end
      vec_cnt++; if (POP !== 1'b0) begin err_cnt++; $display("FAIL stall_pop: got %0b want 0", POP); end
      repeat (5) cycle();
      vec_cnt++; if (dbg_state !== 2'd1) begin err_cnt++; $display("FAIL stall_hold: state %0d want 1", dbg_state); end
      push_n  = 2;
      push_v0 = 8'h55;
      push_v1 = 8'h66;
      cycle();
      push_n  = 0;
`ifdef LIFO_DRAIN_STATS_EN
      vec_cnt++; if (stall_cnt !== 16'd7) begin err_cnt++; $display("FAIL stall_cnt: got %0d want 7", stall_cnt); end
`endif
      exp_q = '{8'h66, 8'h55};
      sink(40, 0, 2, 1'b1, ok);
      vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL stall_timeout2: got %0d words want 2", got_q.size()); end
      for (int k = 0; k < 2; k++) begin
         vec_cnt++;
         if (got_q.size() <= k || got_q[k] !== exp_q[k] || last_q[k] !== (k == 1)) begin
            err_cnt++;
            $display("FAIL stall_refill%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
      vec_cnt++; if (pop_cnt - p0 !== 5) begin err_cnt++; $display("FAIL stall_pops: got %0d want 5", pop_cnt - p0); end
      vec_cnt++; if (bad_pop - b0 !== 0) begin err_cnt++; $display("FAIL stall_pop_empty: got %0d want 0", bad_pop - b0); end
      cycle();
   endtask

   task automatic test_len0_and_busy();
      bit ok;
      int p0;
      lifo_clear();
      for (int k = 1; k <= 4; k++) lifo_push(8'h40 + 8'(k));
      m_ready = 1'b0;
      p0 = pop_cnt;
      send_start(5'd0);
      vec_cnt++; if (done !== 1'b1 || busy !== 1'b0 || POP !== 1'b0) begin err_cnt++; $display("FAIL len0: done %0b busy %0b pop %0b want 1 0 0", done, busy, POP); end
      cycle();
      vec_cnt++; if (done !== 1'b0 || m_valid !== 1'b0 || pop_cnt != p0) begin err_cnt++; $display("FAIL len0_after: done %0b valid %0b pops %0d want 0 0 0", done, m_valid, pop_cnt - p0); end
      // len 3 with sink stalled: only the buffer's worth of pops may issue.
      send_start(5'd3);
      repeat (6) cycle();
      vec_cnt++; if (pop_cnt - p0 !== 2) begin err_cnt++; $display("FAIL throttle_pops: got %0d want 2", pop_cnt - p0); end
      vec_cnt++; if (m_valid !== 1'b1 || m_data !== 8'h44) begin err_cnt++; $display("FAIL throttle_head: valid %0b data %h want 1 44", m_valid, m_data); end
      send_start(5'd4);
      exp_q = '{8'h44, 8'h43, 8'h42};
      sink(40, 0, 3, 1'b1, ok);
      vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL busy_timeout: got %0d words want 3", got_q.size()); end
      for (int k = 0; k < 3; k++) begin
         vec_cnt++;
         if (got_q.size() <= k || got_q[k] !== exp_q[k] || last_q[k] !== (k == 2)) begin
            err_cnt++;
            $display("FAIL busy_word%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
      vec_cnt++; if (pop_cnt - p0 !== 3 || sp !== 5'd1) begin err_cnt++; $display("FAIL busy_pops: pops %0d depth %0d want 3 1", pop_cnt - p0, sp); end
      cycle();
   endtask

   task automatic test_reset_mid_drain();
      bit ok;
      lifo_clear();
      for (int k = 0; k < 8; k++) lifo_push(8'h80 + 8'(k));
      exp_q = '{8'h87, 8'h86, 8'h85, 8'h84};
      send_start(5'd8);
      sink(40, 0, 4, 1'b0, ok);
      vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL rmid_timeout: got %0d words want 4", got_q.size()); end
      for (int k = 0; k < 4; k++) begin
         vec_cnt++;
         if (got_q.size() <= k || got_q[k] !== exp_q[k]) begin
            err_cnt++;
            $display("FAIL rmid_word%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
      Rst = 1'b1;
      #1;
      vec_cnt++; if (busy !== 1'b0 || done !== 1'b0 || POP !== 1'b0) begin err_cnt++; $display("FAIL rmid_ctrl: busy %0b done %0b pop %0b want 0 0 0", busy, done, POP); end
      vec_cnt++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00) begin err_cnt++; $display("FAIL rmid_stream: valid %0b last %0b data %h want 0 0 00", m_valid, m_last, m_data); end
      vec_cnt++; if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rmid_state: got %0d want 0", dbg_state); end
      cycle();
      Rst = 1'b0;
      vec_cnt++; if (sp !== 5'd3) begin err_cnt++; $display("FAIL rmid_depth: got %0d want 3", sp); end
      exp_q = '{8'h82, 8'h81};
      send_start(5'd2);
      sink(40, 0, 2, 1'b1, ok);
      vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL rmid_timeout2: got %0d words want 2", got_q.size()); end
      for (int k = 0; k < 2; k++) begin
         vec_cnt++;
         if (got_q.size() <= k || got_q[k] !== exp_q[k] || last_q[k] !== (k == 1)) begin
            err_cnt++;
            $display("FAIL rmid_restart%0d: got %h want %h", k, (got_q.size() > k) ? got_q[k] : 8'hxx, exp_q[k]);
         end
      end
      cycle();
   endtask

   task automatic test_clamp();
      bit ok;
      int p0;
      lifo_clear();
      for (int k = 0; k < 16; k++) lifo_push(8'hC0 + 8'(k));
      exp_q.delete();
      for (int k = 15; k >= 0; k--) exp_q.push_back(8'hC0 + 8'(k));
      p0 = pop_cnt;
      send_start(5'd31);
      sink(80, 0, 16, 1'b1, ok);
      vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL clamp_timeout: got %0d words want 16", got_q.size()); end
      vec_cnt++; if (got_q.size() !== 16) begin err_cnt++; $display("FAIL clamp_count: got %0d want 16", got_q.size()); end
      vec_cnt++;
      if (got_q.size() < 16 || got_q[0] !== exp_q[0] || got_q[15] !== exp_q[15] || last_q[15] !== 1'b1 || last_q[14] !== 1'b0) begin
         err_cnt++;
         $display("FAIL clamp_ends: first/last words or last flag wrong (size %0d)", got_q.size());
      end
      vec_cnt++; if (pop_cnt - p0 !== 16 || bad_pop !== 0) begin err_cnt++; $display("FAIL clamp_pops: pops %0d bad %0d want 16 0", pop_cnt - p0, bad_pop); end
      cycle();
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL clamp_idle: busy %0b want 0", busy); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      Rst     = 1'b1;
      start   = 1'b0;
      len     = '0;
      m_ready = 1'b0;
      clr     = 1'b0;
      push_n  = 0;
      push_v0 = '0;
      push_v1 = '0;
      repeat (2) @(posedge Clk);
      #1;
      test_reset();
      test_full_drain();
      test_ready_toggle();
      test_empty_stall();
      test_len0_and_busy();
      test_reset_mid_drain();
      test_clamp();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
